ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter_if.sv | 34 +++
 rtl/ram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for ram_port_arbiter.
// A request transfers when req_valid[i] & req_ready[i]; req_valid never depends on req_ready,
// and we/addr/wdata stay stable while valid is high and ready is low.
interface ram_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 2,
    parameter int DW   = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic               wea;
    logic               web;
    logic [AW-1:0]      addra;
    logic [AW-1:0]      addrb;
    logic [DW-1:0]      dina;
    logic [DW-1:0]      dinb;
    logic [DW-1:0]      douta;
    logic [DW-1:0]      doutb;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, douta, doutb,
        output req_ready, rsp_valid, rsp_data, wea, web, addra, addrb, dina, dinb
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, douta, doutb,
        input  req_ready, rsp_valid, rsp_data, wea, web, addra, addrb, dina, dinb
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the two ports of a dual-port RAM between NREQ requesters,
// with same-address hazard blocking and per-port read-return routing.
module ram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 2,
    parameter int DW   = 4,
    parameter int CW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    ram_port_arbiter_if.slave        bus,
    output logic [CW-1:0]            conflict_cnt,
    output logic [$clog2(NREQ)-1:0]  rr_ptr
);
    localparam int PW = $clog2(NREQ);

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    logic [PW-1:0] rr_ptr_q;
    logic          a_hit, b_hit, skip_any;
    logic [PW-1:0] a_id, b_id;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [PW:0]   hi_inc;
    logic [PW-1:0] next_ptr;

    logic          pend_a, pend_b;
    logic [PW-1:0] id_a, id_b;
    logic [CW-1:0] cnt_q;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = bus.req_addr[i*AW +: AW];
            wdata_arr[i] = bus.req_wdata[i*DW +: DW];
        end
    end

    // Scan from rr_ptr; a candidate that hazards with port A is skipped, not the scan.
    always_comb begin
        a_hit    = 1'b0;
        b_hit    = 1'b0;
        skip_any = 1'b0;
        a_id     = '0;
        b_id     = '0;
        a_we     = 1'b0;
        a_addr   = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            idx = sum[PW-1:0];
            if (bus.req_valid[idx]) begin
                if (!a_hit) begin
                    a_hit  = 1'b1;
                    a_id   = idx;
                    a_we   = bus.req_we[idx];
                    a_addr = addr_arr[idx];
                end else if (!b_hit) begin
                    if ((addr_arr[idx] == a_addr) && (a_we || bus.req_we[idx])) begin
                        skip_any = 1'b1;
                    end else begin
                        b_hit = 1'b1;
                        b_id  = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        hi_inc   = {1'b0, (b_hit ? b_id : a_id)} + 1'b1;
        next_ptr = (hi_inc >= (PW+1)'(NREQ)) ? '0 : hi_inc[PW-1:0];
    end

    always_comb begin
        bus.req_ready = '0;
        if (a_hit) bus.req_ready[a_id] = 1'b1;
        if (b_hit) bus.req_ready[b_id] = 1'b1;
        bus.wea   = a_hit & bus.req_we[a_id];
        bus.addra = a_hit ? addr_arr[a_id]  : '0;
        bus.dina  = a_hit ? wdata_arr[a_id] : '0;
        bus.web   = b_hit & bus.req_we[b_id];
        bus.addrb = b_hit ? addr_arr[b_id]  : '0;
        bus.dinb  = b_hit ? wdata_arr[b_id] : '0;
    end

    // RAM dout arrives one cycle after the address, lining up with the registered pend/id.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (pend_a) begin
            bus.rsp_valid[id_a]         = 1'b1;
            bus.rsp_data[id_a*DW +: DW] = bus.douta;
        end
        if (pend_b) begin
            bus.rsp_valid[id_b]         = 1'b1;
            bus.rsp_data[id_b*DW +: DW] = bus.doutb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            id_a     <= '0;
            id_b     <= '0;
            cnt_q    <= '0;
        end else begin
            if (a_hit) rr_ptr_q <= next_ptr;
            pend_a <= a_hit & ~bus.req_we[a_id];
            id_a   <= a_id;
            pend_b <= b_hit & ~bus.req_we[b_id];
            id_b   <= b_id;
            if (skip_any && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign conflict_cnt = cnt_q;
    assign rr_ptr       = rr_ptr_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a vector table stepped once per cycle against a
// behavioural 4x4 dual-port RAM, plus saturation and mid-read reset sequences.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] conflict_cnt;
    logic [1:0] rr_ptr;
    int checks = 0;
    int errors = 0;

    ram_port_arbiter_if #(.NREQ(4), .AW(2), .DW(4)) bus ();

    ram_port_arbiter #(.NREQ(4), .AW(2), .DW(4), .CW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .conflict_cnt (conflict_cnt),
        .rr_ptr       (rr_ptr)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [4];
    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        bus.douta = '0;
        bus.doutb = '0;
    end
    always @(posedge clk) begin
        if (bus.wea) mem[bus.addra] <= bus.dina;
        if (bus.web) mem[bus.addrb] <= bus.dinb;
        bus.douta <= mem[bus.addra];
        bus.doutb <= mem[bus.addrb];
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [3:0]  ready;
        logic [3:0]  rsp_valid;
        logic [15:0] rsp_data;
        logic        wea;
        logic        web;
        logic [1:0]  addra;
        logic [1:0]  addrb;
        logic [3:0]  dina;
        logic [3:0]  dinb;
        logic [7:0]  cnt;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [7:0] pa(input logic [1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(
        input logic [3:0] v, we, input logic [7:0] a, input logic [15:0] d,
        input logic [3:0] rdy, rv, input logic [15:0] rd,
        input logic wa, wb, input logic [1:0] aa, ab, input logic [3:0] da, db,
        input logic [7:0] c, input logic [1:0] p);
        vec_t r;
        r.valid = v; r.we = we; r.addr = a; r.wdata = d;
        r.ready = rdy; r.rsp_valid = rv; r.rsp_data = rd;
        r.wea = wa; r.web = wb; r.addra = aa; r.addrb = ab; r.dina = da; r.dinb = db;
        r.cnt = c; r.ptr = p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, we, input logic [7:0] a, input logic [15:0] d);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic chk_ram_idle(input string tag);
        chk({tag, " wea"},   32'(bus.wea),   32'd0);
        chk({tag, " web"},   32'(bus.web),   32'd0);
        chk({tag, " addra"}, 32'(bus.addra), 32'd0);
        chk({tag, " addrb"}, 32'(bus.addrb), 32'd0);
        chk({tag, " dina"},  32'(bus.dina),  32'd0);
        chk({tag, " dinb"},  32'(bus.dinb),  32'd0);
    endtask

    initial begin
        //            valid we    addr            wdata     ready rsp  rsp_data  wa wb aa ab da    db    cnt ptr
        vecs[0]  = mk(4'h0, 4'h0, 8'h00,          16'h0000, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        vecs[1]  = mk(4'h1, 4'h1, pa(2, 0, 0, 0), 16'h000A, 4'h1, 4'h0, 16'h0000, 1, 0, 2, 0, 4'hA, 4'h0, 0, 0);
        vecs[2]  = mk(4'h1, 4'h0, pa(2, 0, 0, 0), 16'h0000, 4'h1, 4'h0, 16'h0000, 0, 0, 2, 0, 4'h0, 4'h0, 0, 1);
        vecs[3]  = mk(4'h0, 4'h0, 8'h00,          16'h0000, 4'h0, 4'h1, 16'h000A, 0, 0, 0, 0, 4'h0, 4'h0, 0, 1);
        vecs[4]  = mk(4'h6, 4'h6, pa(0, 1, 3, 0), 16'h0C50, 4'h6, 4'h0, 16'h0000, 1, 1, 1, 3, 4'h5, 4'hC, 0, 1);
        vecs[5]  = mk(4'h6, 4'h0, pa(0, 1, 3, 0), 16'h0000, 4'h6, 4'h0, 16'h0000, 0, 0, 1, 3, 4'h0, 4'h0, 0, 3);
        vecs[6]  = mk(4'h0, 4'h0, 8'h00,          16'h0000, 4'h0, 4'h6, 16'h0C50, 0, 0, 0, 0, 4'h0, 4'h0, 0, 3);
        vecs[7]  = mk(4'h8, 4'h0, pa(0, 0, 0, 0), 16'h0000, 4'h8, 4'h0, 16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 0, 3);
        vecs[8]  = mk(4'hB, 4'h3, pa(0, 0, 0, 2), 16'h0093, 4'h9, 4'h8, 16'h0000, 1, 0, 0, 2, 4'h3, 4'h0, 0, 0);
        vecs[9]  = mk(4'h2, 4'h2, pa(0, 0, 0, 0), 16'h0090, 4'h2, 4'h8, 16'hA000, 1, 0, 0, 0, 4'h9, 4'h0, 1, 0);
        vecs[10] = mk(4'h3, 4'h0, pa(1, 1, 0, 0), 16'h0000, 4'h3, 4'h0, 16'h0000, 0, 0, 1, 1, 4'h0, 4'h0, 1, 2);
        vecs[11] = mk(4'h0, 4'h0, 8'h00,          16'h0000, 4'h0, 4'h3, 16'h0055, 0, 0, 0, 0, 4'h0, 4'h0, 1, 2);
        vecs[12] = mk(4'hF, 4'h0, pa(0, 1, 2, 3), 16'h0000, 4'hC, 4'h0, 16'h0000, 0, 0, 2, 3, 4'h0, 4'h0, 1, 2);
        vecs[13] = mk(4'hF, 4'h0, pa(0, 1, 2, 3), 16'h0000, 4'h3, 4'hC, 16'hCA00, 0, 0, 0, 1, 4'h0, 4'h0, 1, 0);
        vecs[14] = mk(4'hF, 4'h0, pa(0, 1, 2, 3), 16'h0000, 4'hC, 4'h3, 16'h0059, 0, 0, 2, 3, 4'h0, 4'h0, 1, 2);
        vecs[15] = mk(4'h0, 4'h0, 8'h00,          16'h0000, 4'h0, 4'hC, 16'hCA00, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0);
        vecs[16] = mk(4'h7, 4'h2, pa(1, 1, 1, 0), 16'h0070, 4'h5, 4'h0, 16'h0000, 0, 0, 1, 1, 4'h0, 4'h0, 1, 0);
        vecs[17] = mk(4'h2, 4'h2, pa(0, 1, 0, 0), 16'h0070, 4'h2, 4'h5, 16'h0505, 1, 0, 1, 0, 4'h7, 4'h0, 2, 3);
        vecs[18] = mk(4'h0, 4'h0, 8'h00,          16'h0000, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 0, 4'h0, 4'h0, 2, 2);

        drive(4'h0, 4'h0, 8'h00, 16'h0000);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("reset conflict",  32'(conflict_cnt),  32'd0);
        chk("reset rr_ptr",    32'(rr_ptr),        32'd0);
        chk("reset ready",     32'(bus.req_ready), 32'd0);
        chk_ram_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #2;
            chk($sformatf("row%0d ready", i),     32'(bus.req_ready), 32'(vecs[i].ready));
            chk($sformatf("row%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].rsp_valid));
            chk($sformatf("row%0d rsp_data", i),  32'(bus.rsp_data),  32'(vecs[i].rsp_data));
            chk($sformatf("row%0d wea", i),       32'(bus.wea),       32'(vecs[i].wea));
            chk($sformatf("row%0d web", i),       32'(bus.web),       32'(vecs[i].web));
            chk($sformatf("row%0d addra", i),     32'(bus.addra),     32'(vecs[i].addra));
            chk($sformatf("row%0d addrb", i),     32'(bus.addrb),     32'(vecs[i].addrb));
            chk($sformatf("row%0d dina", i),      32'(bus.dina),      32'(vecs[i].dina));
            chk($sformatf("row%0d dinb", i),      32'(bus.dinb),      32'(vecs[i].dinb));
            chk($sformatf("row%0d conflict", i),  32'(conflict_cnt),  32'(vecs[i].cnt));
            chk($sformatf("row%0d rr_ptr", i),    32'(rr_ptr),        32'(vecs[i].ptr));
            @(negedge clk);
        end

        // Two writers hammering addr 0: one is deferred every cycle, so the counter climbs to saturation.
        drive(4'h3, 4'h3, pa(0, 0, 0, 0), 16'h0021);
        repeat (10) @(negedge clk);
        #2;
        chk("sat mid conflict", 32'(conflict_cnt), 32'd12);
        chk("sat mid one grant", 32'($countones(bus.req_ready)), 32'd1);
        repeat (290) @(negedge clk);
        #2;
        chk("sat conflict", 32'(conflict_cnt), 32'd255);
        @(negedge clk);
        #2;
        chk("sat hold", 32'(conflict_cnt), 32'd255);
        drive(4'h0, 4'h0, 8'h00, 16'h0000);
        @(negedge clk);

        // Read granted, then reset lands before the edge that would capture it.
        drive(4'h2, 4'h0, pa(0, 1, 0, 0), 16'h0000);
        #2;
        chk("rstmid ready", 32'(bus.req_ready), 32'h2);
        #1;
        rst = 1'b1;
        drive(4'h0, 4'h0, 8'h00, 16'h0000);
        #1;
        chk("rstmid conflict", 32'(conflict_cnt), 32'd0);
        chk("rstmid rr_ptr",   32'(rr_ptr),       32'd0);
        @(negedge clk);
        #2;
        chk("rstmid rsp_valid during", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rstmid rsp_valid after", 32'(bus.rsp_valid), 32'd0);
        chk("rstmid rsp_data after",  32'(bus.rsp_data),  32'd0);
        chk("rstmid rr_ptr after",    32'(rr_ptr),        32'd0);
        chk("rstmid ready after",     32'(bus.req_ready), 32'd0);
        chk_ram_idle("rstmid");
        @(negedge clk);

        drive(4'hA, 4'h0, pa(0, 2, 0, 3), 16'h0000);
        #2;
        chk("post-reset ready", 32'(bus.req_ready), 32'hA);
        chk("post-reset addra", 32'(bus.addra),     32'd2);
        chk("post-reset addrb", 32'(bus.addrb),     32'd3);
        @(negedge clk);
        drive(4'h0, 4'h0, 8'h00, 16'h0000);
        #2;
        chk("post-reset rsp_valid", 32'(bus.rsp_valid), 32'hA);
        chk("post-reset rr_ptr",    32'(rr_ptr),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
